// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef logic master_t;

    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the master that did not win last time wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between the DLX data port and an
// auxiliary master, with a bounded wait for read data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_we,
    input  logic [ADDR_W-1:0] m_addr0,
    input  logic [ADDR_W-1:0] m_addr1,
    input  logic [31:0]       m_wdata0,
    input  logic [31:0]       m_wdata1,
    output logic [1:0]        m_gnt,
    output logic [31:0]       m_rdata,
    output logic [1:0]        m_rvalid,
    output logic              m_rerr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_rdata_valid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    master_t          owner;
    master_t          last;
    logic [CNT_W-1:0] cnt;

    logic [1:0] pick;
    logic [1:0] gnt;
    logic       timed_out;
    logic       done;

    rr_pick2 u_pick (
        .req  (m_req),
        .last (last),
        .gnt  (pick)
    );

    // Grants depend only on registered state, never on ram_rdata_valid.
    assign gnt   = (state == IDLE && reset_n) ? pick : 2'b00;
    assign m_gnt = gnt;

    assign ram_addr  = gnt[1] ? m_addr1  : m_addr0;
    assign ram_wdata = gnt[1] ? m_wdata1 : m_wdata0;
    assign ram_we    = |(gnt & m_we);

    // cnt holds the number of completed wait cycles, so the current cycle is cnt+1.
    assign timed_out = (int'(cnt) + 1 >= TIMEOUT);
    assign done      = (state == RD_WAIT) && (ram_rdata_valid || timed_out);

    assign m_rvalid = done ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign m_rerr   = done && !ram_rdata_valid;
    assign m_rdata  = m_rerr ? ERR_DATA : ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        last <= gnt[1];
                        if (!ram_we) begin
                            state <= RD_WAIT;
                            owner <= gnt[1];
                            cnt   <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (done) begin
                        state <= IDLE;
                    end else if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;

    localparam int TIMEOUT = 15;
    localparam int ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        m_req;
    logic [1:0]        m_we;
    logic [ADDR_W-1:0] m_addr0, m_addr1;
    logic [31:0]       m_wdata0, m_wdata1;
    logic [1:0]        m_gnt;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rvalid;
    logic              m_rerr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_rdata_valid;

    ram_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_req           (m_req),
        .m_we            (m_we),
        .m_addr0         (m_addr0),
        .m_addr1         (m_addr1),
        .m_wdata0        (m_wdata0),
        .m_wdata1        (m_wdata1),
        .m_gnt           (m_gnt),
        .m_rdata         (m_rdata),
        .m_rvalid        (m_rvalid),
        .m_rerr          (m_rerr),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .ram_rdata_valid (ram_rdata_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: a read is outstanding from its grant cycle until
    // data arrives or TIMEOUT cycles have elapsed since the grant.
    logic busy     = 1'b0;
    logic owner    = 1'b0;
    logic last_win = 1'b1;
    int   start    = 0;
    int   cyc      = 0;

    logic [1:0]  cap_gnt, cap_rvalid;
    logic        cap_we, cap_rerr;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic tick();
        logic [1:0]  eg, erv;
        logic        ewe, eerr;
        logic [31:0] ea, ed, erd;
        int          w;
        #4;
        cap_gnt = m_gnt; cap_rvalid = m_rvalid; cap_we = ram_we; cap_rerr = m_rerr;
        cap_addr = ram_addr; cap_wdata = ram_wdata; cap_rdata = m_rdata;

        eg = 2'b00; erv = 2'b00; ewe = 1'b0; eerr = 1'b0; erd = 32'h0;
        ea = m_addr0; ed = m_wdata0; w = -1;
        if (reset_n) begin
            if (!busy) begin
                if (m_req == 2'b11)  w = (last_win == 1'b0) ? 1 : 0;
                else if (m_req[0])   w = 0;
                else if (m_req[1])   w = 1;
                if (w >= 0) begin
                    eg[w] = 1'b1;
                    ewe   = m_we[w];
                    ea    = (w == 1) ? m_addr1  : m_addr0;
                    ed    = (w == 1) ? m_wdata1 : m_wdata0;
                end
            end else if (ram_rdata_valid) begin
                erv[owner] = 1'b1;
                erd        = ram_rdata;
            end else if (cyc - start == TIMEOUT) begin
                erv[owner] = 1'b1;
                eerr       = 1'b1;
                erd        = 32'hDEAD_BEEF;
            end
        end

        check("gnt", 32'(cap_gnt), 32'(eg));
        check("ram_we", 32'(cap_we), 32'(ewe));
        check("ram_addr", cap_addr, ea);
        check("ram_wdata", cap_wdata, ed);
        check("rvalid", 32'(cap_rvalid), 32'(erv));
        if (erv != 2'b00) begin
            check("rerr", 32'(cap_rerr), 32'(eerr));
            check("rdata", cap_rdata, erd);
        end

        if (!reset_n) begin
            busy = 1'b0; last_win = 1'b1;
        end else if (busy) begin
            if (erv != 2'b00) busy = 1'b0;
        end else if (w >= 0) begin
            last_win = (w == 1);
            if (!m_we[w]) begin
                busy = 1'b1; owner = (w == 1); start = cyc;
            end
        end

        @(posedge clk);
        #1;
        if (w >= 0) m_req[w] = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [1:0] exp_g;
        reset_n = 1'b0; m_req = 2'b00; m_we = 2'b00;
        m_addr0 = '0; m_addr1 = '0; m_wdata0 = '0; m_wdata1 = '0;
        ram_rdata = '0; ram_rdata_valid = 1'b0;
        @(posedge clk);
        #1;

        m_req = 2'b11;
        tick();
        check("rst_gnt", 32'(cap_gnt), 32'h0);
        check("rst_rvalid", 32'(cap_rvalid), 32'h0);
        reset_n = 1'b1; m_req = 2'b00;
        tick();

        // Single read by master 0 with a one-cycle RAM.
        m_req = 2'b01; m_we = 2'b00; m_addr0 = 32'h10;
        tick();
        check("rd0_gnt", 32'(cap_gnt), 32'h1);
        check("rd0_addr", cap_addr, 32'h10);
        ram_rdata_valid = 1'b1; ram_rdata = 32'h1234_5678;
        tick();
        check("rd0_rvalid", 32'(cap_rvalid), 32'h1);
        check("rd0_rdata", cap_rdata, 32'h1234_5678);
        check("rd0_rerr", 32'(cap_rerr), 32'h0);
        ram_rdata_valid = 1'b0;

        // Both masters reading continuously: grants alternate, none during the wait.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_req = 2'b11; m_we = 2'b00;
            ram_rdata_valid = busy; ram_rdata = $urandom;
            tick();
            exp_g = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
            check("rr_gnt", 32'(cap_gnt), 32'(exp_g));
        end
        m_req = 2'b00; ram_rdata_valid = 1'b0;

        // Master 0 wins alone, then master 1 writes on a tie and master 0 follows.
        m_req = 2'b01; m_we = 2'b01;
        tick();
        check("wr_pre_gnt", 32'(cap_gnt), 32'h1);
        m_req = 2'b11; m_we = 2'b10; m_addr1 = 32'h20; m_wdata1 = 32'hA5A5_A5A5; m_addr0 = 32'h30;
        tick();
        check("wr1_gnt", 32'(cap_gnt), 32'h2);
        check("wr1_we", 32'(cap_we), 32'h1);
        check("wr1_addr", cap_addr, 32'h20);
        check("wr1_wdata", cap_wdata, 32'hA5A5_A5A5);
        tick();
        check("wr1_next_gnt", 32'(cap_gnt), 32'h1);
        check("wr1_next_we", 32'(cap_we), 32'h0);
        ram_rdata_valid = 1'b1;
        tick();
        ram_rdata_valid = 1'b0; m_we = 2'b00;

        // Read by master 1 that never gets data, then a late response.
        m_req = 2'b10;
        tick();
        check("to_gnt", 32'(cap_gnt), 32'h2);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) begin
                check("to_wait_rvalid", 32'(cap_rvalid), 32'h0);
            end else begin
                check("to_rvalid", 32'(cap_rvalid), 32'h2);
                check("to_rerr", 32'(cap_rerr), 32'h1);
                check("to_rdata", cap_rdata, 32'hDEAD_BEEF);
            end
        end
        ram_rdata_valid = 1'b1;
        tick();
        check("late_rvalid", 32'(cap_rvalid), 32'h0);
        ram_rdata_valid = 1'b0;

        // Reset while a read is outstanding.
        m_req = 2'b01;
        tick();
        reset_n = 1'b0; m_req = 2'b11; ram_rdata_valid = 1'b1;
        tick();
        check("rstw_gnt", 32'(cap_gnt), 32'h0);
        check("rstw_rvalid", 32'(cap_rvalid), 32'h0);
        tick();
        reset_n = 1'b1; ram_rdata_valid = 1'b0;
        tick();
        check("rstw_first_gnt", 32'(cap_gnt), 32'h1);
        ram_rdata_valid = 1'b1;
        tick();
        ram_rdata_valid = 1'b0;

        // Randomized traffic; masters hold requests until granted.
        for (int n = 0; n < 3000; n++) begin
            if (!m_req[0] && $urandom_range(1, 0) == 1) begin
                m_req[0] = 1'b1; m_we[0] = ($urandom_range(2, 0) == 0);
                m_addr0 = $urandom; m_wdata0 = $urandom;
            end
            if (!m_req[1] && $urandom_range(1, 0) == 1) begin
                m_req[1] = 1'b1; m_we[1] = ($urandom_range(2, 0) == 0);
                m_addr1 = $urandom; m_wdata1 = $urandom;
            end
            ram_rdata       = $urandom;
            ram_rdata_valid = ($urandom_range(7, 0) == 0);
            reset_n         = ($urandom_range(199, 0) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: the maximum number of cycles to wait for RAM read data before aborting.
REQ-002 Parameter ADDR_W, default 32: the address width of both masters and of the RAM port.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 m_req[1:0]  in  2  per-master request; master 0 is the DLX data port, master 1 is the auxiliary port.
REQ-006 m_we[1:0]  in  2  per-master write enable, qualified by m_req.
REQ-007 m_addr0, m_addr1  in  ADDR_W each  per-master byte address.
REQ-008 m_wdata0, m_wdata1  in  32 each  per-master write data.
REQ-009 m_gnt[1:0]  out  2  request accepted this cycle, one-hot or zero.
REQ-010 m_rdata  out  32  read data, shared by both masters.
REQ-011 m_rvalid[1:0]  out  2  read completion strobe for each master, one-hot or zero.
REQ-012 m_rerr  out  1  the read completing this cycle timed out; qualified by m_rvalid.
REQ-013 ram_addr  out  ADDR_W  the granted master's address; the RAM decodes the word index itself.
REQ-014 ram_we  out  1  write strobe to the RAM.
REQ-015 ram_wdata  out  32  write data to the RAM.
REQ-016 ram_rdata  in  32  RAM read data.
REQ-017 ram_rdata_valid  in  1  RAM read data valid; at least 1 cycle after the address cycle.

Function
REQ-018 Two-state FSM: IDLE and RD_WAIT.
REQ-019 In IDLE, a grant is issued combinationally in the same cycle as m_req, with at most one grant per cycle.
REQ-020 In RD_WAIT, m_gnt shall be 0 regardless of m_req.
REQ-021 Arbitration is round-robin: with both masters requesting, the master not granted last wins; a single requester always wins.
REQ-022 The last-grant register updates only on a cycle with a nonzero m_gnt.
REQ-023 On grant, ram_addr, ram_we and ram_wdata come combinationally from the granted master, and ram_we equals the granted m_we.
REQ-024 With no grant, ram_we shall be 0, and ram_addr/ram_wdata hold master 0's values (don't-care for the RAM).
REQ-025 A granted write completes in the grant cycle; the FSM stays in IDLE and raises no m_rvalid.
REQ-026 A granted read registers the owner index, clears the timeout counter, and moves the FSM to RD_WAIT.
REQ-027 In RD_WAIT, ram_rdata_valid=1 produces one cycle of m_rvalid[owner]=1, m_rdata=ram_rdata and m_rerr=0, both combinationally, and the FSM returns to IDLE.
REQ-028 The grant path is not combinationally dependent on ram_rdata_valid; a new grant is issued on the cycle after the read completes.
REQ-029 In RD_WAIT, the counter increments every cycle; when it reaches TIMEOUT without data, the block drives m_rvalid[owner]=1, m_rerr=1 and m_rdata=32'hDEAD_BEEF, then returns to IDLE.
REQ-030 A ram_rdata_valid that arrives while in IDLE (a late response after a timeout) shall be ignored.
REQ-031 Changes to a master's m_req while it is not granted are legal; a master shall hold its request until it sees m_gnt.
REQ-032 The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates; it shall never wrap.

Reset
REQ-033 Asserting reset_n=0 at any time, including in RD_WAIT, forces: FSM=IDLE, owner=0, counter=0, last-grant=1 so that master 0 wins the first tie, and m_rvalid=0.
REQ-034 An outstanding read at reset is dropped with no m_rvalid.
REQ-035 Release of reset_n is synchronised externally.
REQ-036 All outputs are defined from the first cycle after reset.

Structure
REQ-037 Package ram_arb_pkg holds the FSM state enum (IDLE, RD_WAIT), the master index type, and the constant ERR_DATA=32'hDEAD_BEEF.
REQ-038 The round-robin selection is the sub-module rr_pick2, a purely combinational block with inputs req[1:0] and last, and output gnt[1:0].
REQ-039 Registers sit only in ram_arbiter: state, owner, counter, and last.

Verification
REQ-040 Read by master 0 alone: m_req=01, m_we=0, m_addr0=0x10, with RAM returning 0x12345678 one cycle later -> m_gnt=01 in cycle 0, m_rvalid=01 and m_rdata=0x12345678 in cycle 1, m_rerr=0.
REQ-041 Both masters request reads continuously, each with a 1-cycle RAM -> grants alternate 01,10,01,10 starting with 01 after reset, and no grant occurs during RD_WAIT.
REQ-042 Master 1 write to 0x20 with data 0xA5A5A5A5 and master 0 requesting in the same cycle after master 0 was last granted -> master 1 granted, ram_we=1 for one cycle, master 0 granted the next cycle.
REQ-043 Read with no ram_rdata_valid, TIMEOUT=15 -> m_rvalid for the owner with m_rerr=1 and m_rdata=0xDEADBEEF 15 cycles after the grant; a late ram_rdata_valid afterwards produces no m_rvalid.
REQ-044 reset_n pulsed low while in RD_WAIT -> m_rvalid=0 and m_gnt=0 during reset; the first request after reset is granted in IDLE with master 0 winning a tie.
